signal_trigger_generator: RTL and testbench

//   Periodic trigger source: emits a registered pulse on `trigger` every DELAY clock cycles.

---
 rtl/signal_trigger_generator.sv | 80 ++++++++
 tb/tb_signal_trigger_generator.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/signal_trigger_generator.sv
// rtl/signal_trigger_generator.sv - periodic trigger pulse source
// Emits a PULSE_WIDTH-cycle pulse every DELAY cycles, with pause, restart, one-shot and a pulse counter.
module signal_trigger_generator #(
   parameter int DELAY       = 10,
   parameter int PULSE_WIDTH = 1,
   parameter int COUNT_W     = 16,
   localparam int PH_W       = ($clog2(DELAY) < 1) ? 1 : $clog2(DELAY)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               enable,
   input  logic               restart,
   input  logic               one_shot,
   output logic               trigger,
   output logic [PH_W-1:0]    phase,
   output logic [COUNT_W-1:0] pulse_count,
   output logic               done
);

   localparam int WC_W = ($clog2(PULSE_WIDTH) < 1) ? 1 : $clog2(PULSE_WIDTH);
   localparam logic [PH_W-1:0] LP_LAST_PHASE = PH_W'(DELAY - 1);
   localparam logic [WC_W-1:0] LP_WIDTH_INIT = WC_W'(PULSE_WIDTH - 1);

   generate
      if (DELAY < 2 || PULSE_WIDTH < 1 || PULSE_WIDTH > DELAY - 1) begin : g_bad_params
         $error("signal_trigger_generator: illegal DELAY/PULSE_WIDTH");
      end
   endgenerate

   logic               r_trigger;
   logic [PH_W-1:0]    r_phase;
   logic [COUNT_W-1:0] r_pulse_count;
   logic               r_done;
   logic [WC_W-1:0]    r_width_cnt;
   logic               w_advance;
   logic               w_wrap;

   assign w_advance = enable && !r_done;
   assign w_wrap    = w_advance && (r_phase == LP_LAST_PHASE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_trigger     <= 1'b0;
         r_phase       <= '0;
         r_pulse_count <= '0;
         r_done        <= 1'b0;
         r_width_cnt   <= '0;
      end else if (restart) begin
         // pulse_count deliberately survives a restart
         r_trigger   <= 1'b0;
         r_phase     <= '0;
         r_done      <= 1'b0;
         r_width_cnt <= '0;
      end else if (w_wrap) begin
         r_trigger     <= 1'b1;
         r_phase       <= '0;
         r_width_cnt   <= LP_WIDTH_INIT;
         r_pulse_count <= r_pulse_count + 1'b1;
         if (one_shot) begin
            r_done <= 1'b1;
         end
      end else begin
         if (w_advance) begin
            r_phase <= r_phase + 1'b1;
         end
         // a pulse in flight finishes even while paused
         if (r_width_cnt != '0) begin
            r_width_cnt <= r_width_cnt - 1'b1;
         end else begin
            r_trigger <= 1'b0;
         end
      end
   end

   assign trigger     = r_trigger;
   assign phase       = r_phase;
   assign pulse_count = r_pulse_count;
   assign done        = r_done;

endmodule

// File: tb/tb_signal_trigger_generator.sv
// tb/tb_signal_trigger_generator.sv - randomized bench against a behavioural trigger model
// Two instances share stimulus: PW=1/16-bit count and PW=3/4-bit count (to reach counter wrap).
module tb_signal_trigger_generator;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable;
   logic       restart;
   logic       one_shot;
   logic       trig1, trig3;
   logic [3:0] phase1, phase3;
   logic [15:0] cnt1;
   logic [3:0]  cnt3;
   logic       done1, done3;

   int n_checks = 0;
   int n_pass   = 0;

   // reference model state: edge index, time of last pulse start, phase, total pulses
   int m_edge      = 0;
   int m_last_rise = -1000;
   int m_phase     = 0;
   int m_count     = 0;
   bit m_done      = 1'b0;

   always #5 clk = ~clk;

   signal_trigger_generator #(.DELAY(10), .PULSE_WIDTH(1), .COUNT_W(16)) u_dut_pw1 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart), .one_shot(one_shot),
      .trigger(trig1), .phase(phase1), .pulse_count(cnt1), .done(done1)
   );

   signal_trigger_generator #(.DELAY(10), .PULSE_WIDTH(3), .COUNT_W(4)) u_dut_pw3 (
      .clk(clk), .rst_n(rst_n), .enable(enable), .restart(restart), .one_shot(one_shot),
      .trigger(trig3), .phase(phase3), .pulse_count(cnt3), .done(done3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, m_edge);
   endtask

   function automatic logic exp_trig(input int pw);
      return (m_edge - m_last_rise) < pw;
   endfunction

   task automatic model_reset();
      m_last_rise = -1000;
      m_phase     = 0;
      m_count     = 0;
      m_done      = 1'b0;
   endtask

   task automatic compare_all();
      check("trig_pw1",  {31'd0, trig1},  {31'd0, exp_trig(1)});
      check("trig_pw3",  {31'd0, trig3},  {31'd0, exp_trig(3)});
      check("phase_pw1", {28'd0, phase1}, m_phase);
      check("phase_pw3", {28'd0, phase3}, m_phase);
      check("count_pw1", {16'd0, cnt1},   m_count & 32'hffff);
      check("count_pw3", {28'd0, cnt3},   m_count & 32'hf);
      check("done_pw1",  {31'd0, done1},  {31'd0, m_done});
      check("done_pw3",  {31'd0, done3},  {31'd0, m_done});
   endtask

   // inputs change at the falling edge; outputs are compared at the next falling edge
   task automatic step(input logic en, input logic rs, input logic os);
      enable   = en;
      restart  = rs;
      one_shot = os;
      @(posedge clk);
      m_edge++;
      if (rs) begin
         m_phase     = 0;
         m_done      = 1'b0;
         m_last_rise = -1000;
      end else if (en && !m_done) begin
         if (m_phase == 9) begin
            m_phase     = 0;
            m_count++;
            m_last_rise = m_edge;
            if (os) m_done = 1'b1;
         end else begin
            m_phase++;
         end
      end
      @(negedge clk);
      compare_all();
   endtask

   task automatic async_reset_pulse();
      rst_n = 1'b0;
      #1;
      check("arst_trig_pw1",  {31'd0, trig1}, 32'd0);
      check("arst_trig_pw3",  {31'd0, trig3}, 32'd0);
      check("arst_phase",     {28'd0, phase1}, 32'd0);
      check("arst_count_pw1", {16'd0, cnt1}, 32'd0);
      check("arst_count_pw3", {28'd0, cnt3}, 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      int base;
      rst_n    = 1'b0;
      enable   = 1'b0;
      restart  = 1'b0;
      one_shot = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      compare_all();
      rst_n = 1'b1;

      // free-running: pulses after edges 10..250
      for (int i = 0; i < 250; i++) step(1'b1, 1'b0, 1'b0);
      check("free_count_pw1", {16'd0, cnt1}, 32'd25);
      check("free_count_pw3", {28'd0, cnt3}, 32'd9);
      check("free_phase",     {28'd0, phase1}, 32'd0);

      // pause at phase 4 for 5 edges
      for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0);
      check("pause_phase", {28'd0, phase1}, 32'd4);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
      check("pause_pulse_at_15", {31'd0, trig1}, 32'd1);

      // one-shot: a single pulse then done
      step(1'b1, 1'b1, 1'b0);
      base = m_count;
      for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b1);
      check("oneshot_done",  {31'd0, done1}, 32'd1);
      check("oneshot_count", {16'd0, cnt1}, (base + 1) & 32'hffff);
      step(1'b1, 1'b1, 1'b0);
      check("restart_clears_done", {31'd0, done1}, 32'd0);
      for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0);
      check("restart_next_pulse", {31'd0, trig1}, 32'd1);

      // restart coinciding with a would-be wrap edge
      while (m_phase != 9) step(1'b1, 1'b0, 1'b0);
      base = m_count;
      step(1'b1, 1'b1, 1'b0);
      check("restart_wrap_trig",  {31'd0, trig1}, 32'd0);
      check("restart_wrap_count", {16'd0, cnt1}, base & 32'hffff);

      // async reset mid-pulse, then first pulse after the 10th edge
      step(1'b1, 1'b0, 1'b0);
      while (!exp_trig(3)) step(1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      async_reset_pulse();
      for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 1'b0);
      check("post_arst_edge9", {31'd0, trig1}, 32'd0);
      step(1'b1, 1'b0, 1'b0);
      check("post_arst_edge10", {31'd0, trig1}, 32'd1);

      // randomized operation
      for (int i = 0; i < 1500; i++) begin
         logic en, rs, os;
         en = ($urandom_range(0, 99) < 80);
         rs = ($urandom_range(0, 99) < 4);
         os = ($urandom_range(0, 99) < 15);
         if (exp_trig(3) && $urandom_range(0, 99) < 5) async_reset_pulse();
         step(en, rs, os);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
